switch_exec_sequencer: RTL and testbench
========================================

Name: switch_exec_sequencer

Overview:
- Parametrised successor to the board-level manual-instruction processor top.
- Accepts one instruction word per request pulse, from the switch bank with front-panel button edge detection done upstream.
- Sequences the instruction through a 4-state FSM: decode, execute, write-back. Holds its own register file and ALU.
- Exposes operand and result buses for the 7-segment converters, plus busy/done/illegal status.

Parameters:
- DATA_W, 16, datapath and register width (>=8).
- REG_AW, 4, register address width; register count = 2**REG_AW; also the immediate field width.
- OPC_W, 4, opcode width; instruction width INSTR_W = OPC_W + 3*REG_AW.
- IMM_SEXT, 0, 1 = sign-extend immediate to DATA_W, 0 = zero-extend.

Ports:
- CLOCK_50  in  1  sole clock, all state on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on CLOCK_50 rising edge.
- instr  in  INSTR_W  fields: [top OPC_W]=opcode, then rd, rs/imm, rt (REG_AW each, rt in LSBs).
- exec_req  in  1  single-cycle execute request.
- inspect_req  in  1  single-cycle register-inspect request.
- disp_a  out  DATA_W  operand A / inspected register A.
- disp_b  out  DATA_W  operand B / inspected register B.
- result  out  DATA_W  last registered ALU result.
- flag_z  out  1  result==0 for last executed op.
- flag_c  out  1  carry-out (ADD/ADDI) or no-borrow (SUB/SUBI); 0 for other ops.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse in WB state.
- illegal  out  1  sticky: last accepted instruction had an undefined opcode.

Behaviour:
- Reset (reset_n=0 at an edge): FSM→IDLE; all registers, disp_a, disp_b, result, flag_z, flag_c, busy, done, illegal →0. This aborts any in-flight instruction with no write.
- States:
  - IDLE: exec_req=1 → latch instr, clear illegal, go to DECODE.
  - IDLE: else inspect_req=1 → disp_a←R[instr rs field], disp_b←R[instr rt field]; stay in IDLE.
  - DECODE → EXEC → WB → IDLE. One cycle each, unconditional.
- exec_req and inspect_req together in IDLE: exec wins, inspect is dropped.
- Requests while busy=1 are ignored and not queued.
- Latency: exec_req accepted at edge N.
  - DECODE during N+1: operand read; disp_a/disp_b updated at end of N+1 (disp_a = rs register value or extended immediate for I-type).
  - EXEC during N+2: result, flag_z, flag_c registered at end of N+2.
  - WB during N+3: done=1; R[rd] written at end of N+3.
  - The write is visible to an exec or inspect accepted at N+4.
- Register file:
  - Combinational read, synchronous write.
  - R0 reads as 0; writes to R0 are discarded (result and flags still update).
- Opcodes (R-type uses R[rs], R[rt]; I-type uses imm=rs field extended per IMM_SEXT, R[rt]):
  - 0 ADD: R[rs]+R[rt].
  - 1 SUB: R[rs]−R[rt].
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed compare, result 1/0.
  - 6 ADDI: R[rt]+imm.
  - 7 SUBI: R[rt]−imm.
  - 8 ANDI, 9 ORI.
  - 10 SLLI: R[rt] << (imm mod DATA_W).
  - 11 SRLI: logical right shift, same shift rule.
  - 12..2**OPC_W−1: illegal. illegal←1 at end of DECODE; no register write; result and flags unchanged; done still pulses in WB.
- Arithmetic is modulo 2**DATA_W. Carry is taken from the DATA_W+1-bit sum.
- busy=1 in DECODE, EXEC, WB.

Test Plan:
- Reset then idle (defaults): all outputs 0; inspect R3/R7 → disp_a=0, disp_b=0.
- ORI, then SUB with borrow (DATA_W=16): exec ORI rd=2, imm=5, rt=0 → done at N+3, R2=0x0005. Then SUB rd=3, rs=0, rt=2 → result=0xFFFB, flag_c=0, flag_z=0.
- Carry, wrap and immediate extension: R4=0xFFFF via ORI/SLLI chain, then ADD rd=5, R4+R4 → result=0xFFFE, flag_c=1. With IMM_SEXT=1, ADDI imm=0xF on R0 → result=0xFFFF.
- R0 and illegal opcodes: ADDI rd=0, imm=3 → result=3, R0 still reads 0. Opcode 13 → illegal=1, done pulses, no register changes; next legal exec clears illegal.
- Handshake boundaries: exec_req reasserted during DECODE/EXEC/WB → ignored, exactly one done. Simultaneous exec_req+inspect_req → only exec runs. Back-to-back: exec at N+4 reads the value written by the previous WB.
- Reset mid-operation: reset_n=0 during EXEC of ADD rd=6 → R6 stays 0, busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/switch_exec_sequencer.sv
`default_nettype none
// =============================================================================
// switch_exec_sequencer : manual-instruction sequencer with its own register file
// and ALU. Each accepted instruction runs DECODE -> EXEC -> WB (one cycle each).
// Revision: 1.0
// =============================================================================
module switch_exec_sequencer #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int OPC_W    = 4,
    parameter int IMM_SEXT = 0,
    localparam int INSTR_W = OPC_W + 3*REG_AW
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               exec_req,
    input  logic               inspect_req,
    output logic [DATA_W-1:0]  disp_a,
    output logic [DATA_W-1:0]  disp_b,
    output logic [DATA_W-1:0]  result,
    output logic               flag_z,
    output logic               flag_c,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    localparam int c_nregs = 2**REG_AW;
    localparam logic [DATA_W-1:0] c_dw = DATA_W'(DATA_W);

    localparam logic [OPC_W-1:0] c_op_add  = OPC_W'(0);
    localparam logic [OPC_W-1:0] c_op_sub  = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_op_and  = OPC_W'(2);
    localparam logic [OPC_W-1:0] c_op_or   = OPC_W'(3);
    localparam logic [OPC_W-1:0] c_op_xor  = OPC_W'(4);
    localparam logic [OPC_W-1:0] c_op_slt  = OPC_W'(5);
    localparam logic [OPC_W-1:0] c_op_addi = OPC_W'(6);
    localparam logic [OPC_W-1:0] c_op_subi = OPC_W'(7);
    localparam logic [OPC_W-1:0] c_op_andi = OPC_W'(8);
    localparam logic [OPC_W-1:0] c_op_ori  = OPC_W'(9);
    localparam logic [OPC_W-1:0] c_op_slli = OPC_W'(10);
    localparam logic [OPC_W-1:0] c_op_srli = OPC_W'(11);
    localparam logic [OPC_W-1:0] c_op_ill  = OPC_W'(12);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [INSTR_W-1:0] r_instr;
    logic [DATA_W-1:0]  r_regs [c_nregs];
    logic [DATA_W-1:0]  r_disp_a;
    logic [DATA_W-1:0]  r_disp_b;
    logic [DATA_W-1:0]  r_result;
    logic               r_flag_z;
    logic               r_flag_c;
    logic               r_illegal;

    logic [OPC_W-1:0]   w_op;
    logic [REG_AW-1:0]  w_rd;
    logic [REG_AW-1:0]  w_rs;
    logic [REG_AW-1:0]  w_rt;
    logic [REG_AW-1:0]  w_in_rs;
    logic [REG_AW-1:0]  w_in_rt;
    logic [DATA_W-1:0]  w_rs_val;
    logic [DATA_W-1:0]  w_rt_val;
    logic [DATA_W-1:0]  w_in_rs_val;
    logic [DATA_W-1:0]  w_in_rt_val;
    logic [DATA_W-1:0]  w_imm;
    logic               w_legal;
    logic               w_itype;
    logic [DATA_W:0]    w_add;
    logic [DATA_W:0]    w_sub_ab;
    logic [DATA_W:0]    w_sub_ba;
    logic [DATA_W-1:0]  w_shamt;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_alu_c;

    // Fields of the latched instruction drive the whole DECODE/EXEC/WB sequence.
    assign w_op = r_instr[INSTR_W-1 -: OPC_W];
    assign w_rd = r_instr[3*REG_AW-1 -: REG_AW];
    assign w_rs = r_instr[2*REG_AW-1 -: REG_AW];
    assign w_rt = r_instr[REG_AW-1:0];

    assign w_in_rs = instr[2*REG_AW-1 -: REG_AW];
    assign w_in_rt = instr[REG_AW-1:0];

    assign w_rs_val    = (w_rs    == '0) ? '0 : r_regs[w_rs];
    assign w_rt_val    = (w_rt    == '0) ? '0 : r_regs[w_rt];
    assign w_in_rs_val = (w_in_rs == '0) ? '0 : r_regs[w_in_rs];
    assign w_in_rt_val = (w_in_rt == '0) ? '0 : r_regs[w_in_rt];

    assign w_legal = (w_op < c_op_ill);
    assign w_itype = w_legal && (w_op >= c_op_addi);

    generate
        if (IMM_SEXT != 0) begin : g_imm_sext
            assign w_imm = {{(DATA_W-REG_AW){w_rs[REG_AW-1]}}, w_rs};
        end else begin : g_imm_zext
            assign w_imm = {{(DATA_W-REG_AW){1'b0}}, w_rs};
        end
    endgenerate

    // EXEC operands are the displayed values: A = R[rs] or imm, B = R[rt].
    assign w_add    = {1'b0, r_disp_a} + {1'b0, r_disp_b};
    assign w_sub_ab = {1'b0, r_disp_a} - {1'b0, r_disp_b};
    assign w_sub_ba = {1'b0, r_disp_b} - {1'b0, r_disp_a};
    assign w_shamt  = r_disp_a % c_dw;

    always_comb begin
        w_alu_res = r_result;
        w_alu_c   = 1'b0;
        case (w_op)
            c_op_add: begin
                w_alu_res = w_add[DATA_W-1:0];
                w_alu_c   = w_add[DATA_W];
            end
            c_op_sub: begin
                w_alu_res = w_sub_ab[DATA_W-1:0];
                w_alu_c   = ~w_sub_ab[DATA_W];
            end
            c_op_and:  w_alu_res = r_disp_a & r_disp_b;
            c_op_or:   w_alu_res = r_disp_a | r_disp_b;
            c_op_xor:  w_alu_res = r_disp_a ^ r_disp_b;
            c_op_slt:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_disp_a) < $signed(r_disp_b))};
            c_op_addi: begin
                w_alu_res = w_add[DATA_W-1:0];
                w_alu_c   = w_add[DATA_W];
            end
            c_op_subi: begin
                w_alu_res = w_sub_ba[DATA_W-1:0];
                w_alu_c   = ~w_sub_ba[DATA_W];
            end
            c_op_andi: w_alu_res = r_disp_b & r_disp_a;
            c_op_ori:  w_alu_res = r_disp_b | r_disp_a;
            c_op_slli: w_alu_res = r_disp_b << w_shamt;
            c_op_srli: w_alu_res = r_disp_b >> w_shamt;
            default: begin
                w_alu_res = r_result;
                w_alu_c   = r_flag_c;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (exec_req) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = ST_EXEC;
            ST_EXEC:   w_state_nxt = ST_WB;
            ST_WB:     w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_instr   <= '0;
            r_disp_a  <= '0;
            r_disp_b  <= '0;
            r_result  <= '0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < c_nregs; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Exec has priority; a simultaneous inspect is dropped.
                    if (exec_req) begin
                        r_instr   <= instr;
                        r_illegal <= 1'b0;
                    end else if (inspect_req) begin
                        r_disp_a <= w_in_rs_val;
                        r_disp_b <= w_in_rt_val;
                    end
                end
                ST_DECODE: begin
                    r_disp_a  <= w_itype ? w_imm : w_rs_val;
                    r_disp_b  <= w_rt_val;
                    r_illegal <= ~w_legal;
                end
                ST_EXEC: begin
                    if (w_legal) begin
                        r_result <= w_alu_res;
                        r_flag_z <= (w_alu_res == '0);
                        r_flag_c <= w_alu_c;
                    end
                end
                ST_WB: begin
                    if (w_legal && (w_rd != '0)) begin
                        r_regs[w_rd] <= r_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign disp_a  = r_disp_a;
    assign disp_b  = r_disp_b;
    assign result  = r_result;
    assign flag_z  = r_flag_z;
    assign flag_c  = r_flag_c;
    assign illegal = r_illegal;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_WB);

endmodule
`default_nettype wire

// File: tb/tb_switch_exec_sequencer.sv
`default_nettype none
// =============================================================================
// tb_switch_exec_sequencer : zero- and sign-extending instances driven in
// parallel, checked each cycle against a transaction-level reference model.
// Revision: 1.0
// =============================================================================
module tb_switch_exec_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        exec_req;
    logic        inspect_req;
    logic [15:0] instr;

    logic [1:0][15:0] da, db, res;
    logic [1:0]       fz, fc, busy, done, ill;

    always #5 CLOCK_50 = ~CLOCK_50;

    switch_exec_sequencer #(.DATA_W(16), .REG_AW(4), .OPC_W(4), .IMM_SEXT(0)) u_dut0 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .instr(instr), .exec_req(exec_req),
        .inspect_req(inspect_req), .disp_a(da[0]), .disp_b(db[0]), .result(res[0]),
        .flag_z(fz[0]), .flag_c(fc[0]), .busy(busy[0]), .done(done[0]), .illegal(ill[0])
    );

    switch_exec_sequencer #(.DATA_W(16), .REG_AW(4), .OPC_W(4), .IMM_SEXT(1)) u_dut1 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .instr(instr), .exec_req(exec_req),
        .inspect_req(inspect_req), .disp_a(da[1]), .disp_b(db[1]), .result(res[1]),
        .flag_z(fz[1]), .flag_c(fc[1]), .busy(busy[1]), .done(done[1]), .illegal(ill[1])
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int dcount   = 0;

    // Reference model: one entry per instance (0 = zero-extend, 1 = sign-extend)
    logic [15:0] m_regs [2][16];
    logic [15:0] m_da[2], m_db[2], m_res[2];
    bit          m_z[2], m_c[2], m_ill[2], m_dknown[2];
    int          m_cyc[2];
    logic [15:0] p_da[2], p_db[2], p_res[2];
    bit          p_z[2], p_c[2], p_legal[2];
    logic [3:0]  p_rd[2];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-instruction effect, computed once at acceptance from the rules.
    task automatic compute(input int k);
        logic [3:0]  op, rd, rs, rt;
        logic [15:0] a, b, imm, r;
        int          s, sa, sb, sh;
        bit          c;
        {op, rd, rs, rt} = instr;
        a   = m_regs[k][rs];
        b   = m_regs[k][rt];
        imm = (k == 1 && rs[3]) ? {12'hFFF, rs} : {12'h000, rs};
        sh  = int'(imm) % 16;
        sa  = int'(a) - (a[15] ? 65536 : 0);
        sb  = int'(b) - (b[15] ? 65536 : 0);
        r   = 16'h0;
        c   = 1'b0;
        case (op)
            4'd0:  begin s = int'(a) + int'(b);   r = s[15:0]; c = (s > 65535); end
            4'd1:  begin s = int'(a) - int'(b);   r = s[15:0]; c = (a >= b);    end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = (sa < sb) ? 16'd1 : 16'd0;
            4'd6:  begin s = int'(b) + int'(imm); r = s[15:0]; c = (s > 65535); end
            4'd7:  begin s = int'(b) - int'(imm); r = s[15:0]; c = (b >= imm);  end
            4'd8:  r = b & imm;
            4'd9:  r = b | imm;
            4'd10: begin s = int'(b) << sh; r = s[15:0]; end
            4'd11: r = b >> sh;
            default: r = 16'h0;
        endcase
        p_legal[k] = (op < 4'd12);
        p_rd[k]    = rd;
        p_da[k]    = (op >= 4'd6 && op <= 4'd11) ? imm : a;
        p_db[k]    = b;
        p_res[k]   = r;
        p_z[k]     = (r == 16'h0);
        p_c[k]     = c;
    endtask

    // m_cyc counts cycles since acceptance: 1 decode, 2 exec, 3 write-back.
    task automatic model_step(input int k);
        if (!reset_n) begin
            for (int r = 0; r < 16; r++) m_regs[k][r] = 16'h0;
            m_da[k] = 16'h0; m_db[k] = 16'h0; m_res[k] = 16'h0;
            m_z[k] = 1'b0; m_c[k] = 1'b0; m_ill[k] = 1'b0; m_dknown[k] = 1'b1;
            m_cyc[k] = 0;
        end else if (m_cyc[k] == 0) begin
            if (exec_req) begin
                compute(k);
                m_ill[k] = 1'b0;
                m_cyc[k] = 1;
            end else if (inspect_req) begin
                m_da[k] = m_regs[k][instr[7:4]];
                m_db[k] = m_regs[k][instr[3:0]];
                m_dknown[k] = 1'b1;
            end
        end else if (m_cyc[k] == 1) begin
            m_da[k] = p_da[k];
            m_db[k] = p_db[k];
            m_dknown[k] = p_legal[k];
            m_ill[k] = !p_legal[k];
            m_cyc[k] = 2;
        end else if (m_cyc[k] == 2) begin
            if (p_legal[k]) begin
                m_res[k] = p_res[k]; m_z[k] = p_z[k]; m_c[k] = p_c[k];
            end
            m_cyc[k] = 3;
        end else begin
            if (p_legal[k] && p_rd[k] != 4'd0) m_regs[k][p_rd[k]] = p_res[k];
            m_cyc[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic exec_op(input logic [3:0] op, input logic [3:0] rd,
                           input logic [3:0] rs, input logic [3:0] rt);
        instr = {op, rd, rs, rt};
        exec_req = 1'b1;
        tick();
        exec_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic inspect(input logic [3:0] rs, input logic [3:0] rt);
        instr = {8'h00, rs, rt};
        inspect_req = 1'b1;
        tick();
        inspect_req = 1'b0;
    endtask

    always @(negedge CLOCK_50) begin
        if (done[0]) dcount++;
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk1 ($sformatf("busy%0d", k),    busy[k], m_cyc[k] != 0);
                chk1 ($sformatf("done%0d", k),    done[k], m_cyc[k] == 3);
                chk1 ($sformatf("illegal%0d", k), ill[k],  m_ill[k]);
                chk16($sformatf("result%0d", k),  res[k],  m_res[k]);
                chk1 ($sformatf("flag_z%0d", k),  fz[k],   m_z[k]);
                chk1 ($sformatf("flag_c%0d", k),  fc[k],   m_c[k]);
                if (m_dknown[k]) begin
                    chk16($sformatf("disp_a%0d", k), da[k], m_da[k]);
                    chk16($sformatf("disp_b%0d", k), db[k], m_db[k]);
                end
            end
        end
    end

    initial begin
        int d0;
        reset_n = 1'b0; exec_req = 1'b0; inspect_req = 1'b0; instr = 16'h0;
        tick();
        chk_en = 1'b1;
        tick();
        reset_n = 1'b1;

        chk16("rst_result", res[0], 16'h0);
        chk1 ("rst_busy",   busy[0], 1'b0);
        chk1 ("rst_illegal", ill[0], 1'b0);
        chk1 ("rst_flag_c", fc[0], 1'b0);
        inspect(4'd3, 4'd7);
        chk16("insp_r3", da[0], 16'h0);
        chk16("insp_r7", db[0], 16'h0);

        // ORI rd=2 imm=5 rt=0, done visible in the third cycle after acceptance
        instr = {4'd9, 4'd2, 4'd5, 4'd0};
        exec_req = 1'b1;
        tick();
        exec_req = 1'b0;
        tick();
        tick();
        chk1("ori_done_wb", done[0], 1'b1);
        tick();
        chk1("ori_done_end", done[0], 1'b0);
        chk16("model_r2", m_regs[0][2], 16'h0005);
        inspect(4'd2, 4'd0);
        chk16("insp_r2", da[0], 16'h0005);

        exec_op(4'd1, 4'd3, 4'd0, 4'd2);
        chk16("sub_result", res[0], 16'hFFFB);
        chk1 ("sub_flag_c", fc[0], 1'b0);
        chk1 ("sub_flag_z", fz[0], 1'b0);

        // Build R4 = 0xFFFF with ORI/SLLI in both instances
        exec_op(4'd9, 4'd4, 4'd15, 4'd0);
        for (int i = 0; i < 3; i++) begin
            exec_op(4'd10, 4'd4, 4'd4, 4'd4);
            exec_op(4'd9, 4'd4, 4'd15, 4'd4);
        end
        inspect(4'd4, 4'd4);
        chk16("r4_zext", da[0], 16'hFFFF);
        chk16("r4_sext", da[1], 16'hFFFF);
        exec_op(4'd0, 4'd5, 4'd4, 4'd4);
        chk16("add_wrap", res[0], 16'hFFFE);
        chk1 ("add_carry", fc[0], 1'b1);

        exec_op(4'd6, 4'd1, 4'd15, 4'd0);
        chk16("addi_zext", res[0], 16'h000F);
        chk16("addi_sext", res[1], 16'hFFFF);

        exec_op(4'd6, 4'd0, 4'd3, 4'd0);
        chk16("addi_r0_result", res[0], 16'h0003);
        inspect(4'd0, 4'd0);
        chk16("r0_reads_zero", da[0], 16'h0);

        d0 = dcount;
        exec_op(4'd13, 4'd6, 4'd4, 4'd4);
        chk1 ("illegal_set", ill[0], 1'b1);
        chk16("illegal_done", 16'(dcount - d0), 16'd1);
        chk16("illegal_result", res[0], 16'h0003);
        inspect(4'd4, 4'd6);
        chk16("illegal_no_write", db[0], 16'h0);
        exec_op(4'd4, 4'd7, 4'd2, 4'd2);
        chk1("illegal_cleared", ill[0], 1'b0);
        chk1("xor_zero", fz[0], 1'b1);

        // exec_req held through DECODE/EXEC/WB: exactly one execution
        d0 = dcount;
        instr = {4'd9, 4'd7, 4'd3, 4'd0};
        exec_req = 1'b1;
        repeat (4) tick();
        exec_req = 1'b0;
        tick();
        chk16("held_req_one_done", 16'(dcount - d0), 16'd1);
        chk16("held_req_result", res[0], 16'h0003);

        instr = {4'd0, 4'd8, 4'd7, 4'd7};
        exec_req = 1'b1; inspect_req = 1'b1;
        tick();
        exec_req = 1'b0; inspect_req = 1'b0;
        repeat (3) tick();
        chk16("exec_over_inspect", res[0], 16'h0006);
        exec_op(4'd0, 4'd9, 4'd8, 4'd8);
        chk16("back_to_back", res[0], 16'h000C);

        // Reset during EXEC aborts the instruction
        d0 = dcount;
        instr = {4'd0, 4'd6, 4'd2, 4'd2};
        exec_req = 1'b1;
        tick();
        exec_req = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk1("abort_busy", busy[0], 1'b0);
        tick();
        tick();
        chk16("abort_no_done", 16'(dcount - d0), 16'd0);
        inspect(4'd6, 4'd2);
        chk16("abort_r6", da[0], 16'h0);

        for (int n = 0; n < 3000; n++) begin
            reset_n     = ($urandom_range(0, 299) != 0);
            exec_req    = ($urandom_range(0, 99) < 35);
            inspect_req = ($urandom_range(0, 99) < 25);
            instr       = 16'($urandom);
            if ($urandom_range(0, 4) != 0) instr[15:12] = 4'($urandom_range(0, 11));
            tick();
        end
        reset_n = 1'b1; exec_req = 1'b0; inspect_req = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
